// File: rtl/arbiter_8way_if.sv
// Request/grant bundle between the requesting units and the 8-way arbiter.
// The master side drives requests; the slave side (the arbiter) drives the grant view.
interface arbiter_8way_if;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       preempt;

   modport master (output req, input grant, grant_id, grant_valid, preempt);
   modport slave  (input req, output grant, grant_id, grant_valid, preempt);
endinterface

// File: rtl/arbiter_8way.sv
// Registered round-robin arbiter sharing one downstream resource among 8 requesters,
// with an optional hold timeout that revokes a long-held grant when others are waiting.
module arbiter_8way #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic           clock,
   input  logic           reset,
   arbiter_8way_if.slave  bus
);

   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       GRANT    = 1'b1;
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam bit               HOLD_EN  = (MAX_HOLD != 0);

   logic [0:0]       state;
   logic [7:0]       grant_r;
   logic [2:0]       grant_id_r;
   logic             preempt_r;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       last_id;
   logic [2:0]       winner;
   logic             others_pending;

   // Scan from the farthest offset back toward last_id+1 so the nearest requester wins;
   // the previous owner (offset 8) therefore has the lowest priority.
   always_comb begin
      winner = last_id;
      for (int i = 8; i >= 1; i--) begin
         if (bus.req[last_id + 3'(i)]) begin
            winner = last_id + 3'(i);
         end
      end
   end

   assign others_pending = |(bus.req & ~grant_r);

   // Every release or revocation passes through IDLE, which gives downstream a switch cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         grant_r    <= '0;
         grant_id_r <= '0;
         preempt_r  <= 1'b0;
         hold_cnt   <= '0;
         last_id    <= 3'd7;
      end else begin
         preempt_r <= 1'b0;
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  grant_r    <= 8'b1 << winner;
                  grant_id_r <= winner;
                  last_id    <= winner;
                  hold_cnt   <= CNT_W'(1);
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (!bus.req[grant_id_r]) begin
                  grant_r    <= '0;
                  grant_id_r <= '0;
                  state      <= IDLE;
               end else if (HOLD_EN && hold_cnt == HOLD_MAX && others_pending) begin
                  grant_r    <= '0;
                  grant_id_r <= '0;
                  preempt_r  <= 1'b1;
                  state      <= IDLE;
               end else if (HOLD_EN && hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant       = grant_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.grant_valid = |grant_r;
   assign bus.preempt     = preempt_r;

endmodule

// File: tb/tb_arbiter_8way.sv
// Directed self-checking bench for arbiter_8way built with MAX_HOLD=4 so the timeout path is reachable.
module tb_arbiter_8way;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic check_on = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   arbiter_8way_if bus ();

   arbiter_8way #(.MAX_HOLD(4), .CNT_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Structural invariants on every cycle once the design has been reset.
   always @(negedge clock) begin
      if (check_on) begin
         vectors++;
         if (($countones(bus.grant) > 1) || (bus.grant_valid !== (bus.grant != 8'h00)) ||
             ((bus.grant == 8'h00) ? (bus.grant_id !== 3'd0) : (bus.grant !== (8'b1 << bus.grant_id)))) begin
            miscompares++;
            $display("[TB] FAIL invariant: grant=%h grant_id=%0d grant_valid=%b", bus.grant, bus.grant_id, bus.grant_valid);
         end
      end
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset   = 1'b1;
      bus.req = 8'h00;
      step;
      reset   = 1'b0;
   endtask

   task automatic test_reset;
      logic [12:0] obs;
      reset   = 1'b1;
      bus.req = 8'hFF;
      step;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      vectors++;
      if (obs !== 13'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: observed %h expected %h", obs, 13'h0);
      end
      check_on = 1'b1;
      reset    = 1'b0;
      bus.req  = 8'h00;
   endtask

   task automatic test_basic_grant;
      logic [12:0] obs, expected;
      bus.req = 8'h01;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h01, 3'd0, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL basic_grant: observed %h expected %h", obs, expected);
      end
      bus.req = 8'h00;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      vectors++;
      if (obs !== 13'h0) begin
         miscompares++;
         $display("[TB] FAIL basic_release: observed %h expected %h", obs, 13'h0);
      end
   endtask

   task automatic test_round_robin;
      logic [12:0] obs, expected;
      do_reset;
      bus.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         step;
         obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
         expected = {8'b1 << (k % 8), 3'(k % 8), 1'b1, 1'b0};
         vectors++;
         if (obs !== expected) begin
            miscompares++;
            $display("[TB] FAIL round_robin_grant[%0d]: observed %h expected %h", k, obs, expected);
         end
         bus.req = 8'hFF & ~(8'b1 << (k % 8));
         step;
         obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
         vectors++;
         if (obs !== 13'h0) begin
            miscompares++;
            $display("[TB] FAIL round_robin_idle[%0d]: observed %h expected %h", k, obs, 13'h0);
         end
         bus.req = 8'hFF;
      end
      bus.req = 8'h00;
      step;
   endtask

   task automatic test_preempt;
      logic [12:0] obs, expected;
      do_reset;
      bus.req = 8'h04;
      for (int c = 0; c < 4; c++) begin
         step;
         obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
         expected = {8'h04, 3'd2, 1'b1, 1'b0};
         vectors++;
         if (obs !== expected) begin
            miscompares++;
            $display("[TB] FAIL preempt_hold[%0d]: observed %h expected %h", c, obs, expected);
         end
         bus.req = 8'h24;
      end
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h00, 3'd0, 1'b0, 1'b1};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL preempt_pulse: observed %h expected %h", obs, expected);
      end
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h20, 3'd5, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL preempt_next_owner: observed %h expected %h", obs, expected);
      end
      bus.req = 8'h00;
      step;
   endtask

   task automatic test_lone_holder;
      logic [12:0] obs, expected;
      do_reset;
      bus.req = 8'h08;
      for (int c = 0; c < 20; c++) begin
         step;
         obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
         expected = {8'h08, 3'd3, 1'b1, 1'b0};
         vectors++;
         if (obs !== expected) begin
            miscompares++;
            $display("[TB] FAIL lone_holder[%0d]: observed %h expected %h", c, obs, expected);
         end
      end
      bus.req = 8'h00;
      step;
   endtask

   task automatic test_pointer_wrap;
      logic [12:0] obs, expected;
      do_reset;
      bus.req = 8'h40;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h40, 3'd6, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL wrap_setup: observed %h expected %h", obs, expected);
      end
      bus.req = 8'h00;
      step;
      bus.req = 8'h81;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h80, 3'd7, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL wrap_first: observed %h expected %h", obs, expected);
      end
      bus.req = 8'h01;
      step;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h01, 3'd0, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL wrap_second: observed %h expected %h", obs, expected);
      end
      bus.req = 8'h00;
      step;
   endtask

   task automatic test_reset_mid_grant;
      logic [12:0] obs, expected;
      do_reset;
      bus.req = 8'h10;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h10, 3'd4, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_setup: observed %h expected %h", obs, expected);
      end
      reset = 1'b1;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      vectors++;
      if (obs !== 13'h0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_clear: observed %h expected %h", obs, 13'h0);
      end
      reset   = 1'b0;
      bus.req = 8'hFF;
      step;
      obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.preempt};
      expected = {8'h01, 3'd0, 1'b1, 1'b0};
      vectors++;
      if (obs !== expected) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_pointer: observed %h expected %h", obs, expected);
      end
      bus.req = 8'h00;
      step;
   endtask

   initial begin
      bus.req = 8'h00;
      test_reset;
      test_basic_grant;
      test_round_robin;
      test_preempt;
      test_lone_holder;
      test_pointer_wrap;
      test_reset_mid_grant;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/arbiter_8way.md
Name: arbiter_8way

Overview:
- Registered round-robin arbiter that shares one downstream resource (ALU / memory port) among 8 requesters.
- Grant is held while the owner keeps its request high; released on request drop.
- A hold-timeout can preempt the owner when others are waiting.
- Sits between requesting units and the shared datapath. grant_valid is the 8-way OR of grant.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles before forced release if another requester is pending. 0 disables preemption.
- CNT_W, 5: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  request per requester; bit i = requester i.
- grant  out  8  registered one-hot grant; all-zero when idle.
- grant_id  out  3  binary index of current owner; 0 when grant is 0.
- grant_valid  out  1  high when any grant bit is set.
- preempt  out  1  one-cycle pulse on the cycle grant is revoked by timeout.

Behaviour:
- Reset (reset=1 at edge): state=IDLE, grant=0, grant_id=0, grant_valid=0, preempt=0, hold_cnt=0, last_id=7. Reset overrides every other event. An active grant drops on the same edge.
- States: IDLE, GRANT.
- IDLE, req==0: stay IDLE; outputs 0.
- IDLE, req!=0: winner = first set bit scanning last_id+1, +2, ... +8 (mod 8).
  - Next edge: grant=onehot(winner), grant_id=winner, grant_valid=1, last_id=winner, hold_cnt=1, state=GRANT.
  - Latency: request sampled at edge t, grant visible after edge t+1.
- GRANT, priority order at each edge:
  - (a) req[grant_id]==0: grant=0, grant_id=0, grant_valid=0, state=IDLE; no preempt.
  - (b) else if MAX_HOLD!=0, hold_cnt==MAX_HOLD, and (req & ~grant)!=0: grant=0, grant_id=0, grant_valid=0, preempt=1 for this one cycle, state=IDLE.
  - (c) else: hold grant. hold_cnt increments, saturating at MAX_HOLD.
- At least one idle cycle (grant==0) always separates consecutive grants, including a re-grant to the same requester. Downstream uses this as the switch cycle.
- Fairness:
  - last_id updates only on a new grant.
  - After release or preemption, the released owner has the lowest priority.
  - Any continuously asserted requester is granted within 8 grant epochs.
- A lone requester is never preempted. Condition (b) requires another pending request.
- Requests arriving mid-grant are ignored until the next IDLE arbitration; no queuing.
- Request changes on non-owner bits during GRANT do not affect grant.
- preempt is 0 in every cycle except the one after a timeout revocation edge.
- Invariants checked by bench:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches grant.

Test Plan:
- Basic grant: reset, then req=0x01 held -> grant=0x01, grant_id=0, grant_valid=1 after the next edge. Drop req -> grant=0x00 one edge later.
- Round-robin: req=0xFF; each owner drops its bit 1 cycle after grant, then re-raises -> grant order 0x01,0x02,0x04,…,0x80,0x01, with one idle cycle between each.
- Preemption (MAX_HOLD=4):
  - req[2] held, req[5] raised during the grant -> grant=0x04 for exactly 4 cycles.
  - Then grant=0x00 with preempt=1 for one cycle.
  - Next cycle grant=0x20.
- Lone holder (MAX_HOLD=4): only req[3] held 20 cycles -> grant stays 0x08 throughout; preempt never asserts.
- Pointer wrap: after requester 6 granted and released, req=0x81 -> grant=0x80 first. After its release, grant=0x01.
- Reset mid-grant: grant=0x10 active, reset=1 for one edge -> all outputs 0 next cycle. Then req=0xFF -> grant=0x01 (last_id reset to 7).
